// File: rtl/data_memory_hs.sv
// RV32 byte-addressed data memory with a valid/ready request/response handshake and one outstanding transaction.
// Latency LATENCY cycles from acceptance to rsp_valid; RESP holds its outputs indefinitely while rsp_ready=0.
module data_memory_hs #(
    parameter int ADDR_W  = 12,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault,
    output logic [1:0]  rsp_code
);

    localparam int         DEPTH    = 1 << ADDR_W;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_cnt, w_cnt_nxt;
    logic [7:0]  r_mem [DEPTH];

    logic        w_accept, w_enter_resp;
    logic        w_illegal, w_misaligned, w_oor, w_fault;
    logic [1:0]  w_code, w_size_m1;
    logic [32:0] w_last;
    logic [ADDR_W-1:0] w_idx0, w_idx1, w_idx2, w_idx3;
    logic [31:0] w_word, w_load_data, w_rsp_data;

    logic [31:0] r_pend_rdata, r_rsp_rdata;
    logic        r_pend_fault, r_rsp_fault;
    logic [1:0]  r_pend_code, r_rsp_code;

    assign req_ready = (r_state == S_IDLE);
    assign rsp_valid = (r_state == S_RESP);
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_fault = r_rsp_fault;
    assign rsp_code  = r_rsp_code;

    // A request arriving while reset is high must not touch the array.
    assign w_accept = req_valid && (r_state == S_IDLE) && !reset;

    always_comb begin
        w_size_m1 = 2'd0;
        case (req_funct3[1:0])
            2'b01:   w_size_m1 = 2'd1;
            2'b10:   w_size_m1 = 2'd3;
            default: w_size_m1 = 2'd0;
        endcase
        w_illegal    = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                       (req_funct3 == 3'b111) || (req_funct3[2] && req_we);
        w_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                       ((req_funct3 == 3'b010) && (req_addr[1:0] != 2'b00));
        w_last       = {1'b0, req_addr} + {31'b0, w_size_m1};
        w_oor        = |w_last[32:ADDR_W];
        w_fault      = w_illegal || w_misaligned || w_oor;
        w_code       = w_illegal ? 2'b11 : (w_misaligned ? 2'b01 : (w_oor ? 2'b10 : 2'b00));
    end

    assign w_idx0 = req_addr[ADDR_W-1:0];
    assign w_idx1 = w_idx0 + ADDR_W'(1);
    assign w_idx2 = w_idx0 + ADDR_W'(2);
    assign w_idx3 = w_idx0 + ADDR_W'(3);
    assign w_word = {r_mem[w_idx3], r_mem[w_idx2], r_mem[w_idx1], r_mem[w_idx0]};

    always_comb begin
        w_load_data = 32'd0;
        case (req_funct3)
            3'b000:  w_load_data = {{24{w_word[7]}}, w_word[7:0]};
            3'b001:  w_load_data = {{16{w_word[15]}}, w_word[15:0]};
            3'b010:  w_load_data = w_word;
            3'b100:  w_load_data = {24'd0, w_word[7:0]};
            3'b101:  w_load_data = {16'd0, w_word[15:0]};
            default: w_load_data = 32'd0;
        endcase
    end

    assign w_rsp_data = (w_fault || req_we) ? 32'd0 : w_load_data;

    // Array contents survive reset, so this block has no reset term.
    always_ff @(posedge clk) begin
        if (w_accept && req_we && !w_fault) begin
            r_mem[w_idx0] <= req_wdata[7:0];
            if (w_size_m1 != 2'd0) begin
                r_mem[w_idx1] <= req_wdata[15:8];
            end
            if (w_size_m1 == 2'd3) begin
                r_mem[w_idx2] <= req_wdata[23:16];
                r_mem[w_idx3] <= req_wdata[31:24];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (LATENCY == 1) begin
                        w_state_nxt = S_RESP;
                        w_cnt_nxt   = 4'd0;
                    end else begin
                        w_state_nxt = S_WAIT;
                        w_cnt_nxt   = CNT_INIT;
                    end
                end
            end
            S_WAIT: begin
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    assign w_enter_resp = (w_state_nxt == S_RESP) && (r_state != S_RESP);

    // Results are captured at acceptance but only become visible on entry to RESP.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend_rdata <= 32'd0;
            r_pend_fault <= 1'b0;
            r_pend_code  <= 2'b00;
            r_rsp_rdata  <= 32'd0;
            r_rsp_fault  <= 1'b0;
            r_rsp_code   <= 2'b00;
        end else begin
            if (w_accept) begin
                r_pend_rdata <= w_rsp_data;
                r_pend_fault <= w_fault;
                r_pend_code  <= w_code;
            end
            if (w_enter_resp) begin
                if (r_state == S_IDLE) begin
                    r_rsp_rdata <= w_rsp_data;
                    r_rsp_fault <= w_fault;
                    r_rsp_code  <= w_code;
                end else begin
                    r_rsp_rdata <= r_pend_rdata;
                    r_rsp_fault <= r_pend_fault;
                    r_rsp_code  <= r_pend_code;
                end
            end
        end
    end

endmodule

// File: tb/tb_data_memory_hs.sv
// Bench for data_memory_hs: directed literal checks plus randomized traffic against a transaction-level model.
module tb_data_memory_hs;
    localparam int ADDR_W = 12;
    localparam int LAT    = 2;
    localparam int DEPTH  = 1 << ADDR_W;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b1;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
    logic        req_ready, rsp_valid, rsp_fault;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_code;

    int checks = 0;
    int errors = 0;

    data_memory_hs #(.ADDR_W(ADDR_W), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_fault(rsp_fault), .rsp_code(rsp_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: byte array plus one outstanding transaction tracked by cycle number.
    logic [7:0]  m_mem [DEPTH];
    bit          m_known [DEPTH];
    bit          m_busy = 0, m_vis = 0;
    longint      m_cyc = 0, m_acc = 0;
    logic [31:0] m_pend_rdata = 0, m_out_rdata = 0;
    bit          m_pend_known = 1, m_out_known = 1;
    bit          m_pend_fault = 0, m_out_fault = 0;
    logic [1:0]  m_pend_code = 0, m_out_code = 0;

    task automatic model_accept(input bit we, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd);
        int size;
        int idx;
        bit ill, mis, oor, kn;
        logic [31:0] v;
        case (f3)
            3'b000, 3'b100: size = 1;
            3'b001, 3'b101: size = 2;
            3'b010:         size = 4;
            default:        size = 0;
        endcase
        ill = (size == 0) || (we && f3[2]);
        mis = !ill && ((a & 32'(size - 1)) != 0);
        oor = !ill && !mis && (({32'd0, a} + 64'(size) - 64'd1) >= 64'(DEPTH));
        m_pend_fault = ill || mis || oor;
        m_pend_code  = ill ? 2'd3 : (mis ? 2'd1 : (oor ? 2'd2 : 2'd0));
        v  = 32'd0;
        kn = 1;
        if (!m_pend_fault) begin
            for (int i = 0; i < size; i++) begin
                idx = int'(a[ADDR_W-1:0]) + i;
                if (we) begin
                    m_mem[idx]   = wd[8*i +: 8];
                    m_known[idx] = 1;
                end else begin
                    v[8*i +: 8] = m_mem[idx];
                    kn = kn && m_known[idx];
                end
            end
            if (!we && f3 == 3'b000 && v[7])  v[31:8]  = 24'hFFFFFF;
            if (!we && f3 == 3'b001 && v[15]) v[31:16] = 16'hFFFF;
        end
        m_pend_rdata = v;
        m_pend_known = kn;
    endtask

    always @(posedge clk or posedge reset) begin
        bit consume, accept;
        if (reset) begin
            m_busy = 0; m_vis = 0;
            m_out_rdata = 0; m_out_known = 1; m_out_fault = 0; m_out_code = 0;
        end else begin
            consume = m_vis && rsp_ready;
            accept  = !m_busy && req_valid;
            m_cyc++;
            if (consume) begin
                m_busy = 0;
                m_vis  = 0;
            end
            if (accept) begin
                model_accept(req_we, req_funct3, req_addr, req_wdata);
                m_busy = 1;
                m_acc  = m_cyc;
            end
            if (m_busy && !m_vis && m_cyc >= m_acc + LAT - 1) begin
                m_vis = 1;
                m_out_rdata = m_pend_rdata; m_out_known = m_pend_known;
                m_out_fault = m_pend_fault; m_out_code  = m_pend_code;
            end
        end
    end

    always @(negedge clk) begin
        check("req_ready", 32'(req_ready), 32'(!m_busy));
        check("rsp_valid", 32'(rsp_valid), 32'(m_vis));
        if (m_out_known) check("rsp_rdata", rsp_rdata, m_out_rdata);
        check("rsp_fault", 32'(rsp_fault), 32'(m_out_fault));
        check("rsp_code", 32'(rsp_code), 32'(m_out_code));
    end

    logic [31:0] rd;
    logic        flt;
    logic [1:0]  cd;
    int          lat;

    // Starts and ends at posedge+2; consumes the response only if rsp_ready is high.
    task automatic txn(input bit we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] o_rd, output logic o_flt, output logic [1:0] o_cd,
                       output int o_lat);
        int n;
        req_valid = 1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++; errors++;
            $display("FAIL accept_timeout: got req_ready=0 expected 1 within 50 cycles");
        end
        @(posedge clk);
        #2 req_valid = 0;
        o_lat = 1;
        @(negedge clk);
        while (!rsp_valid && o_lat < 40) begin
            @(negedge clk);
            o_lat++;
        end
        if (o_lat >= 40) begin
            checks++; errors++;
            $display("FAIL rsp_timeout: got rsp_valid=0 expected 1 within 40 cycles");
        end
        o_rd = rsp_rdata; o_flt = rsp_fault; o_cd = rsp_code;
        @(posedge clk);
        #2;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_code", 32'(rsp_code), 32'd0);
        @(posedge clk);
        #2 reset = 0;

        txn(1, 3'b010, 32'h100, 32'h0, rd, flt, cd, lat);
        txn(1, 3'b010, 32'h100, 32'hDEADBEEF, rd, flt, cd, lat);
        check("sw_latency", 32'(lat), 32'd2);
        check("sw_rdata", rd, 32'd0);
        check("sw_fault", 32'(flt), 32'd0);
        txn(0, 3'b010, 32'h100, 32'h0, rd, flt, cd, lat);
        check("lw_deadbeef", rd, 32'hDEADBEEF);
        txn(0, 3'b000, 32'h100, 32'h0, rd, flt, cd, lat);
        check("lb", rd, 32'hFFFFFFEF);
        txn(0, 3'b100, 32'h100, 32'h0, rd, flt, cd, lat);
        check("lbu", rd, 32'h000000EF);
        txn(0, 3'b001, 32'h102, 32'h0, rd, flt, cd, lat);
        check("lh", rd, 32'hFFFFDEAD);
        txn(0, 3'b101, 32'h102, 32'h0, rd, flt, cd, lat);
        check("lhu", rd, 32'h0000DEAD);

        txn(1, 3'b010, 32'h100, 32'h0, rd, flt, cd, lat);
        txn(1, 3'b000, 32'h101, 32'hAAAAAA55, rd, flt, cd, lat);
        txn(1, 3'b001, 32'h102, 32'hBBBB1234, rd, flt, cd, lat);
        txn(0, 3'b010, 32'h100, 32'h0, rd, flt, cd, lat);
        check("partial_lw", rd, 32'h12345500);

        txn(0, 3'b010, 32'h102, 32'h0, rd, flt, cd, lat);
        check("misaligned_code", {29'd0, flt, cd}, 32'h5);
        check("misaligned_rdata", rd, 32'd0);
        txn(1, 3'b010, 32'h102, 32'hFFFFFFFF, rd, flt, cd, lat);
        txn(0, 3'b010, 32'h100, 32'h0, rd, flt, cd, lat);
        check("mem_unchanged", rd, 32'h12345500);
        txn(1, 3'b010, 32'hFFC, 32'hA5C3E10F, rd, flt, cd, lat);
        check("sw_top_legal", {29'd0, flt, cd}, 32'h0);
        txn(0, 3'b010, 32'hFFC, 32'h0, rd, flt, cd, lat);
        check("lw_top", rd, 32'hA5C3E10F);
        txn(1, 3'b010, 32'h1000, 32'h1, rd, flt, cd, lat);
        check("oor_code", {29'd0, flt, cd}, 32'h6);
        check("oor_latency", 32'(lat), 32'd2);
        txn(0, 3'b001, 32'hFFF, 32'h0, rd, flt, cd, lat);
        check("mis_over_oor", {29'd0, flt, cd}, 32'h5);
        txn(0, 3'b011, 32'h100, 32'h0, rd, flt, cd, lat);
        check("illegal_011", {29'd0, flt, cd}, 32'h7);
        txn(1, 3'b100, 32'h100, 32'h0, rd, flt, cd, lat);
        check("illegal_sbu", {29'd0, flt, cd}, 32'h7);

        rsp_ready = 0;
        txn(0, 3'b010, 32'h100, 32'h0, rd, flt, cd, lat);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rdata", rsp_rdata, 32'h12345500);
            check("bp_req_ready", 32'(req_ready), 32'd0);
            @(posedge clk);
            #2;
        end
        rsp_ready = 1;
        @(posedge clk);
        #2;
        @(negedge clk);
        check("bp_release_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #2;

        req_valid = 1; req_we = 1; req_funct3 = 3'b010; req_addr = 32'h104; req_wdata = 32'hCAFEF00D;
        @(posedge clk);
        #2 req_valid = 0;
        reset = 1;
        @(negedge clk);
        check("midrst_req_ready", 32'(req_ready), 32'd1);
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst_rsp_rdata", rsp_rdata, 32'd0);
        check("midrst_rsp_code", 32'(rsp_code), 32'd0);
        @(posedge clk);
        #2 reset = 0;
        txn(0, 3'b010, 32'h104, 32'h0, rd, flt, cd, lat);
        check("store_survives_reset", rd, 32'hCAFEF00D);

        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #2;
            if (reset) reset = 0;
            else if ($urandom_range(0, 399) == 0) reset = 1;
            rsp_ready  = ($urandom_range(0, 3) != 0);
            req_valid  = $urandom_range(0, 1);
            req_we     = $urandom_range(0, 1);
            req_funct3 = 3'($urandom_range(0, 7));
            req_wdata  = $urandom;
            case ($urandom_range(0, 7))
                0, 1, 2, 3, 4: req_addr = 32'h100 + 32'($urandom_range(0, 63));
                5:             req_addr = 32'hFF8 + 32'($urandom_range(0, 7));
                6:             req_addr = 32'h1000 + 32'($urandom_range(0, 3));
                default:       req_addr = $urandom;
            endcase
        end
        @(posedge clk);
        #2;
        reset = 0; req_valid = 0; rsp_ready = 1;
        repeat (20) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
